// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single byte-wide sram port between the loader,
// video fetch and CPU. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
// The ack is registered, so it appears in the cycle after DONE. While any
// ack is high the arbiter does not grant, so a requester drops req on its ack.
// Optional macro ARB_CPU_FAIRNESS_EN: after VID_MAX consecutive video grants
// with the CPU waiting, the CPU is preferred over video (loader still highest).
module sram_arbiter #(
    parameter int AW      = 25,
    parameter int TIMEOUT = 63
`ifdef ARB_CPU_FAIRNESS_EN
    ,
    parameter int VID_MAX = 4
`endif
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_din,
    output logic          ld_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic          timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_VID, OWN_CPU} owner_t;

    localparam logic [5:0] TO_LIM = 6'(TIMEOUT);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          op_we_q, op_we_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_rd_q, mem_rd_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    cnt_inc;
    logic [7:0]    rdata_q, rdata_d;
    logic          ld_ack_q, ld_ack_d;
    logic          vid_ack_q, vid_ack_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          terr_q, terr_d;
    logic          ack_any;
    logic          cpu_first;

    assign ack_any = ld_ack_q | vid_ack_q | cpu_ack_q;

`ifdef ARB_CPU_FAIRNESS_EN
    localparam int RUN_W = $clog2(VID_MAX + 1);
    logic [RUN_W-1:0] vid_run_q, vid_run_d;

    assign cpu_first = cpu_req && (vid_run_q == RUN_W'(VID_MAX));

    // Consecutive video-grant counter used to let a waiting CPU through
    always_ff @(posedge clk_sys) begin
        if (reset) vid_run_q <= '0;
        else       vid_run_q <= vid_run_d;
    end
`else
    assign cpu_first = 1'b0;
`endif

    // Arbitration, access sequencing and output next-state
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        din_d     = din_q;
        op_we_d   = op_we_q;
        mem_we_d  = 1'b0;
        mem_rd_d  = 1'b0;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ld_ack_d  = 1'b0;
        vid_ack_d = 1'b0;
        cpu_ack_d = 1'b0;
        terr_d    = terr_q;
`ifdef ARB_CPU_FAIRNESS_EN
        vid_run_d = vid_run_q;
`endif
        cnt_inc   = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;

        unique case (state_q)
            S_IDLE: begin
                if (!ack_any) begin
                    if (ld_req) begin
                        owner_d = OWN_LD;
                        addr_d  = ld_addr;
                        din_d   = ld_din;
                        op_we_d = ld_we;
`ifdef ARB_CPU_FAIRNESS_EN
                        vid_run_d = '0;
`endif
                    end else if (cpu_req && (cpu_first || !vid_req)) begin
                        owner_d = OWN_CPU;
                        addr_d  = cpu_addr;
                        din_d   = cpu_din;
                        op_we_d = cpu_we;
`ifdef ARB_CPU_FAIRNESS_EN
                        vid_run_d = '0;
`endif
                    end else if (vid_req) begin
                        owner_d = OWN_VID;
                        addr_d  = vid_addr;
                        op_we_d = 1'b0;
`ifdef ARB_CPU_FAIRNESS_EN
                        vid_run_d = cpu_req ? vid_run_q + 1'b1 : '0;
`endif
                    end
                    if (owner_d != OWN_NONE) begin
                        state_d  = S_ISSUE;
                        mem_we_d = op_we_d;
                        mem_rd_d = !op_we_d;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_ready) begin
                    if (!op_we_q) rdata_d = mem_dout;
                    state_d = S_DONE;
                end else if (cnt_inc >= TO_LIM) begin
                    terr_d = 1'b1;
                    if (!op_we_q) rdata_d = 8'hFF;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                unique case (owner_q)
                    OWN_LD:  ld_ack_d  = 1'b1;
                    OWN_VID: vid_ack_d = 1'b1;
                    OWN_CPU: cpu_ack_d = 1'b1;
                    default: ;
                endcase
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= '0;
            din_q     <= '0;
            op_we_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ld_ack_q  <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            op_we_q   <= op_we_d;
            mem_we_q  <= mem_we_d;
            mem_rd_q  <= mem_rd_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ld_ack_q  <= ld_ack_d;
            vid_ack_q <= vid_ack_d;
            cpu_ack_q <= cpu_ack_d;
            terr_q    <= terr_d;
        end
    end

    assign ld_ack      = ld_ack_q;
    assign vid_ack     = vid_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign rdata       = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign mem_we      = mem_we_q;
    assign mem_rd      = mem_rd_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios for sram_arbiter with a simple
// fixed-latency sram responder.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_din = '0;
    logic          ld_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic          cpu_ack;
    logic [7:0]    rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we, mem_rd;
    logic [7:0]    mem_dout = '0;
    logic          mem_ready = 1'b0;
    logic          timeout_err;

    int   checks = 0;
    int   errors = 0;

    logic       rsp_en = 1'b1;
    int         rsp_lat = 1;
    logic [7:0] rsp_data = 8'h00;
    logic       stray = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // sram model: mem_ready pulses rsp_lat cycles after the ISSUE cycle
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ready = 1'b0;
            if (stray) begin
                mem_ready = 1'b1;
                mem_dout  = 8'h77;
                stray     = 1'b0;
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = rsp_data;
                end
            end
            if ((mem_we || mem_rd) && rsp_en) rcnt = rsp_lat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ld_ack, vid_ack, cpu_ack, mem_we, mem_rd, timeout_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {ld_ack, vid_ack, cpu_ack, mem_we, mem_rd, timeout_err});
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", mem_addr);
        end
        checks++;
        if ({mem_din, rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: din %h rdata %h want 00 00", mem_din, rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write();
        int lat, nwe, nrd;
        logic seen;
        lat = 0; nwe = 0; nrd = 0; seen = 1'b0;
        rsp_en = 1'b1; rsp_lat = 2;
        cpu_we = 1'b1; cpu_addr = 25'h0000123; cpu_din = 8'hA5; cpu_req = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 25'h0000123 || mem_din !== 8'hA5) begin
                    errors++;
                    $display("FAIL cpu_wr_issue: we %b addr %h din %h want 1 0000123 a5", mem_we, mem_addr, mem_din);
                end
            end
            if (mem_we) nwe++;
            if (mem_rd) nrd++;
            if (cpu_ack) begin
                seen = 1'b1; lat = c; cpu_req = 1'b0;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL cpu_wr_latency: got %0d want 5", lat);
        end
        checks++;
        if (nwe !== 1 || nrd !== 0) begin
            errors++;
            $display("FAIL cpu_wr_pulses: we %0d rd %0d want 1 0", nwe, nrd);
        end
        tick();
    endtask

    task automatic test_video_read();
        int lat;
        logic seen;
        logic [7:0] rd_at_ack;
        lat = 0; seen = 1'b0; rd_at_ack = 8'h00;
        rsp_lat = 1; rsp_data = 8'h3C;
        vid_addr = 25'h00ABCDE; vid_req = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (vid_ack) begin
                seen = 1'b1; lat = c; rd_at_ack = rdata; vid_req = 1'b0;
            end
        end
        checks++;
        if (lat !== 4 || rd_at_ack !== 8'h3C) begin
            errors++;
            $display("FAIL vid_read: latency %0d rdata %h want 4 3c", lat, rd_at_ack);
        end
        tick();
        seen = 1'b0; rsp_data = 8'hEE;
        cpu_we = 1'b1; cpu_addr = 25'h0000010; cpu_din = 8'h99; cpu_req = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (cpu_ack) begin
                seen = 1'b1; rd_at_ack = rdata; cpu_req = 1'b0;
            end
        end
        checks++;
        if (!seen || rd_at_ack !== 8'h3C) begin
            errors++;
            $display("FAIL rdata_hold: acked %b rdata %h want 1 3c", seen, rd_at_ack);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int nack, niss, dual;
        int ord[3];
        logic [AW-1:0] iss[3];
        nack = 0; niss = 0; dual = 0;
        for (int i = 0; i < 3; i++) begin ord[i] = 0; iss[i] = '0; end
        rsp_lat = 1; rsp_data = 8'h42;
        ld_we = 1'b1; ld_addr = 25'h1000000; ld_din = 8'h11;
        vid_addr = 25'h0000200;
        cpu_we = 1'b0; cpu_addr = 25'h0000300;
        ld_req = 1'b1; vid_req = 1'b1; cpu_req = 1'b1;
        for (int c = 1; c <= 60 && nack < 3; c++) begin
            tick();
            if ($countones({ld_ack, vid_ack, cpu_ack}) > 1) dual++;
            if ((mem_we || mem_rd) && niss < 3) begin iss[niss] = mem_addr; niss++; end
            if (ld_ack  && nack < 3) begin ord[nack] = 1; nack++; ld_req  = 1'b0; end
            if (vid_ack && nack < 3) begin ord[nack] = 2; nack++; vid_req = 1'b0; end
            if (cpu_ack && nack < 3) begin ord[nack] = 3; nack++; cpu_req = 1'b0; end
        end
        checks++;
        if (dual !== 0) begin
            errors++;
            $display("FAIL sim_dual_ack: got %0d cycles with >1 ack want 0", dual);
        end
        checks++;
        if (nack !== 3 || ord[0] !== 1 || ord[1] !== 2 || ord[2] !== 3) begin
            errors++;
            $display("FAIL sim_order: got %0d acks order %0d %0d %0d want 3 acks 1 2 3", nack, ord[0], ord[1], ord[2]);
        end
        checks++;
        if (iss[0] !== 25'h1000000 || iss[1] !== 25'h0000200 || iss[2] !== 25'h0000300) begin
            errors++;
            $display("FAIL sim_addrs: got %h %h %h want 1000000 0000200 0000300", iss[0], iss[1], iss[2]);
        end
        ld_we = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        rsp_lat = 1;
        vid_addr = 25'h0000400; cpu_we = 1'b0; cpu_addr = 25'h0000500;
`ifdef ARB_CPU_FAIRNESS_EN
        begin
            int nack;
            int ord[6];
            nack = 0;
            for (int i = 0; i < 6; i++) ord[i] = 0;
            vid_req = 1'b1; cpu_req = 1'b1;
            for (int c = 1; c <= 100 && nack < 6; c++) begin
                tick();
                if (vid_ack && nack < 6) begin ord[nack] = 2; nack++; end
                if (cpu_ack && nack < 6) begin ord[nack] = 3; nack++; cpu_req = 1'b0; end
                if (nack == 6) vid_req = 1'b0;
            end
            vid_req = 1'b0; cpu_req = 1'b0;
            checks++;
            if (nack !== 6 || ord[0] !== 2 || ord[1] !== 2 || ord[2] !== 2 || ord[3] !== 2 || ord[4] !== 3 || ord[5] !== 2) begin
                errors++;
                $display("FAIL fair_order: got %0d acks %0d %0d %0d %0d %0d %0d want 2 2 2 2 3 2",
                         nack, ord[0], ord[1], ord[2], ord[3], ord[4], ord[5]);
            end
        end
`else
        begin
            int nv, nc;
            logic seen;
            nv = 0; nc = 0; seen = 1'b0;
            vid_req = 1'b1; cpu_req = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                tick();
                if (vid_ack) nv++;
                if (cpu_ack) nc++;
            end
            checks++;
            if (nv !== 8 || nc !== 0) begin
                errors++;
                $display("FAIL starve: vid acks %0d cpu acks %0d want 8 0", nv, nc);
            end
            vid_req = 1'b0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                tick();
                if (cpu_ack) begin seen = 1'b1; cpu_req = 1'b0; end
            end
            cpu_req = 1'b0;
            checks++;
            if (seen !== 1'b1) begin
                errors++;
                $display("FAIL starve_release: cpu ack %b want 1", seen);
            end
        end
`endif
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int lat;
        logic seen, terr_before, terr_at;
        logic [7:0] rd_at;
        lat = 0; seen = 1'b0; terr_before = 1'bx; terr_at = 1'b0; rd_at = 8'h00;
        rsp_en = 1'b0;
        cpu_we = 1'b0; cpu_addr = 25'h0000777; cpu_req = 1'b1;
        for (int c = 1; c <= 100 && !seen; c++) begin
            tick();
            if (c == 64) terr_before = timeout_err;
            if (cpu_ack) begin
                seen = 1'b1; lat = c; terr_at = timeout_err; rd_at = rdata; cpu_req = 1'b0;
            end
        end
        checks++;
        if (lat !== 66) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want 66", lat);
        end
        checks++;
        if (terr_before !== 1'b0 || terr_at !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: before %b at ack %b want 0 1", terr_before, terr_at);
        end
        checks++;
        if (rd_at !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_rdata: got %h want ff", rd_at);
        end
        tick();
        rsp_en = 1'b1; rsp_lat = 2; seen = 1'b0; lat = 0;
        cpu_we = 1'b1; cpu_addr = 25'h0000778; cpu_din = 8'h12; cpu_req = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (cpu_ack) begin
                seen = 1'b1; lat = c; terr_at = timeout_err; rd_at = rdata; cpu_req = 1'b0;
            end
        end
        checks++;
        if (lat !== 5 || terr_at !== 1'b1 || rd_at !== 8'hFF) begin
            errors++;
            $display("FAIL after_timeout: latency %0d terr %b rdata %h want 5 1 ff", lat, terr_at, rd_at);
        end
        tick();
    endtask

    task automatic test_mid_drop();
        int lat;
        logic seen;
        lat = 0; seen = 1'b0;
        rsp_lat = 3;
        ld_we = 1'b1; ld_addr = 25'h1ABCDEF; ld_din = 8'h5A; ld_req = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 25'h1ABCDEF) begin
                    errors++;
                    $display("FAIL drop_issue: we %b addr %h want 1 1abcdef", mem_we, mem_addr);
                end
                ld_req = 1'b0; ld_addr = '0; ld_din = 8'h00; ld_we = 1'b0;
            end
            if (c == 3) begin
                checks++;
                if (mem_addr !== 25'h1ABCDEF || mem_din !== 8'h5A) begin
                    errors++;
                    $display("FAIL drop_latched: addr %h din %h want 1abcdef 5a", mem_addr, mem_din);
                end
            end
            if (ld_ack) begin seen = 1'b1; lat = c; end
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL drop_ack: latency %0d want 6", lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int at[2];
        n = 0; at[0] = 0; at[1] = 0;
        rsp_lat = 1; rsp_data = 8'h21;
        cpu_we = 1'b0; cpu_addr = 25'h0000042; cpu_req = 1'b1;
        for (int c = 1; c <= 30 && n < 2; c++) begin
            tick();
            if (cpu_ack) begin
                at[n] = c; n++;
                if (n == 2) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (n !== 2 || at[0] !== 4 || at[1] !== 9) begin
            errors++;
            $display("FAIL back_to_back: %0d acks at %0d %0d want 2 at 4 9", n, at[0], at[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        rsp_en = 1'b0;
        vid_addr = 25'h0000055; vid_req = 1'b1;
        repeat (3) tick();
        reset = 1'b1; vid_req = 1'b0;
        tick();
        checks++;
        if ({ld_ack, vid_ack, cpu_ack, mem_we, mem_rd, timeout_err} !== 6'b0 || mem_addr !== '0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: ctl %b addr %h rdata %h want 000000 0 00",
                     {ld_ack, vid_ack, cpu_ack, mem_we, mem_rd, timeout_err}, mem_addr, rdata);
        end
        reset = 1'b0; rsp_en = 1'b1; stray = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ld_ack || vid_ack || cpu_ack || mem_we || mem_rd) bad++;
        end
        checks++;
        if (bad !== 0 || rdata !== 8'h00) begin
            errors++;
            $display("FAIL stray_ready: active cycles %0d rdata %h want 0 00", bad, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_video_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_mid_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
